// File: rtl/cache_fill_fsm_pkg.sv
// cache_pkg: shared constants and state type for the cache miss-fill controller.
//   WORDS_PER_BLOCK : 16-bit words per cache block (power of two)
//   OFFSET_W        : log2(WORDS_PER_BLOCK), word-offset width
//   BLOCK_BYTES     : block size in bytes
//   fill_state_t    : controller state encoding
package cache_pkg;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W        = 3;
  localparam int BLOCK_BYTES     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;
endpackage

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: bundles the CPU-side miss signals, the memory read port and
// the cache array write controls of one fill controller.
//   master : the fill controller (drives stall, memory request, array writes)
//   slave  : the surrounding cache / memory / pipeline
import cache_pkg::*;

interface cache_fill_fsm_if #(
  parameter int ADDR_W   = 16,
  parameter int OFFSET_W = cache_pkg::OFFSET_W
);
  logic                miss_detected;
  logic [ADDR_W-1:0]   miss_address;
  logic [15:0]         memory_data;
  logic                memory_data_valid;
  logic                fsm_busy;
  logic                memory_request;
  logic [ADDR_W-1:0]   memory_address;
  logic                write_data_array;
  logic [OFFSET_W-1:0] data_array_word;
  logic                write_tag_array;
  logic                critical_word_valid;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, memory_request, memory_address, write_data_array,
           data_array_word, write_tag_array, critical_word_valid
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, memory_request, memory_address, write_data_array,
           data_array_word, write_tag_array, critical_word_valid
  );
endinterface

// File: rtl/cache_fill_fsm_counter.sv
// fill_word_counter: word counter for one side of a block fill.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   i_clr : synchronous clear (start of a fill)
//   i_inc : count one word
//   o_cnt : current count, saturates at MAX_CNT
import cache_pkg::*;

module fill_word_counter #(
  parameter int MAX_CNT = cache_pkg::WORDS_PER_BLOCK,
  parameter int W       = cache_pkg::OFFSET_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  localparam logic [W-1:0] SAT = W'(MAX_CNT);

  logic [W-1:0] r_cnt;

  // Saturating so a stray increment after the last word can never wrap
  // back into the block and re-issue or re-write word 0.
  always_ff @(posedge clk) begin
    if (rst || i_clr)               r_cnt <= '0;
    else if (i_inc && r_cnt != SAT) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-fill controller between a cache and the pipelined word memory.
// On a miss it stalls the pipeline, issues WORDS_PER_BLOCK back-to-back reads,
// writes each returning word into the data array and writes the tag with the
// last word. Responses are counted, so any memory latency works.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : cache_fill_fsm_if.master (miss in, memory port, array write controls)
// Build option CACHE_FILL_CRITICAL_WORD_FIRST_EN: start the fill at the missed
// word, wrap within the block, and flag the first response as the critical word.
import cache_pkg::*;

module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int OFFSET_W        = cache_pkg::OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_fsm_if.master  bus
);
  localparam logic [OFFSET_W:0] CNT_MAX  = (OFFSET_W+1)'(WORDS_PER_BLOCK);
  localparam logic [OFFSET_W:0] CNT_LAST = CNT_MAX - 1'b1;
  localparam int                BASE_W   = ADDR_W - OFFSET_W - 1;

  fill_state_t         r_state;
  logic [BASE_W-1:0]   r_block_base;
  logic [OFFSET_W:0]   w_issue_cnt, w_recv_cnt;
  logic                w_start, w_fill, w_req, w_wr, w_last;
  logic [OFFSET_W-1:0] w_issue_word, w_recv_word;

  assign w_fill  = (r_state == FILL);
  assign w_start = (r_state == IDLE) & bus.miss_detected;
  assign w_req   = w_fill & (w_issue_cnt < CNT_MAX);
  // Responses outside a fill (stale data after a reset) are dropped here.
  assign w_wr    = w_fill & bus.memory_data_valid;
  assign w_last  = w_wr & (w_recv_cnt == CNT_LAST);

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [OFFSET_W-1:0] r_start_off;
  // Offsets add modulo the block size by truncation to OFFSET_W bits.
  assign w_issue_word            = r_start_off + w_issue_cnt[OFFSET_W-1:0];
  assign w_recv_word             = r_start_off + w_recv_cnt[OFFSET_W-1:0];
  assign bus.critical_word_valid = w_wr & (w_recv_cnt == '0);
`else
  assign w_issue_word            = w_issue_cnt[OFFSET_W-1:0];
  assign w_recv_word             = w_recv_cnt[OFFSET_W-1:0];
  assign bus.critical_word_valid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_block_base <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      r_start_off  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (bus.miss_detected) begin
          r_state      <= FILL;
          r_block_base <= bus.miss_address[ADDR_W-1:OFFSET_W+1];
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
          r_start_off  <= bus.miss_address[OFFSET_W:1];
`endif
        end
        // New misses are not looked at until the block is complete.
        FILL: if (w_last) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  fill_word_counter #(.MAX_CNT(WORDS_PER_BLOCK), .W(OFFSET_W+1)) u_issue_cnt (
    .clk(clk), .rst(rst), .i_clr(w_start), .i_inc(w_req), .o_cnt(w_issue_cnt)
  );

  fill_word_counter #(.MAX_CNT(WORDS_PER_BLOCK), .W(OFFSET_W+1)) u_recv_cnt (
    .clk(clk), .rst(rst), .i_clr(w_start), .i_inc(w_wr), .o_cnt(w_recv_cnt)
  );

  // Stall is combinational so the pipeline holds in the miss cycle itself.
  assign bus.fsm_busy         = w_fill | w_start;
  assign bus.memory_request   = w_req;
  assign bus.memory_address   = {r_block_base, w_issue_word, 1'b0};
  assign bus.write_data_array = w_wr;
  assign bus.data_array_word  = w_recv_word;
  assign bus.write_tag_array  = w_last;

  // Low address bits and the data bus pass the controller untouched.
  logic w_unused;
  assign w_unused = &{1'b0, bus.miss_address[OFFSET_W:0], bus.memory_data};
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed bench for cache_fill_fsm with a 4-cycle pipelined
// memory model returning 16'hA000 + address[3:0] for each request.
import cache_pkg::*;

module tb_cache_fill_fsm;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_fsm_if bus();
  cache_fill_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;
  int cyc = 0, gap = 0, gap_cnt = 0;
  logic [15:0] q_addr[$];
  int          q_due[$];

  logic        busy_h[64], req_h[64], wr_h[64], tag_h[64], cwv_h[64];
  logic [15:0] addr_h[64], data_h[64];
  logic [2:0]  word_h[64];

  function automatic logic [2:0] exp_word(logic [2:0] start, int n);
    logic [2:0] nn;
    nn = 3'(n);
    return CWF ? 3'(start + nn) : nn;
  endfunction

  // Memory model: sample the request this cycle, advance one edge, present data.
  task automatic tick();
    logic [15:0] a;
    if (bus.memory_request === 1'b1) begin
      q_addr.push_back(bus.memory_address);
      q_due.push_back(cyc + 4);
    end
    @(posedge clk); cyc++; #1;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;
    if (gap_cnt > 0) gap_cnt--;
    else if (q_due.size() > 0 && q_due[0] <= cyc) begin
      a = q_addr.pop_front();
      void'(q_due.pop_front());
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'hA000 + {12'h0, a[3:0]};
      gap_cnt = gap;
    end
  endtask

  task automatic step();
    #1;
    if (cyc >= 0 && cyc < 64) begin
      busy_h[cyc] = bus.fsm_busy;         req_h[cyc]  = bus.memory_request;
      addr_h[cyc] = bus.memory_address;   wr_h[cyc]   = bus.write_data_array;
      word_h[cyc] = bus.data_array_word;  data_h[cyc] = bus.memory_data;
      tag_h[cyc]  = bus.write_tag_array;  cwv_h[cyc]  = bus.critical_word_valid;
    end
    tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.miss_detected = 1'b0; bus.miss_address = '0;
    bus.memory_data_valid = 1'b0; bus.memory_data = '0;
    q_addr.delete(); q_due.delete(); gap = 0; gap_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.miss_detected = 1'b0; bus.miss_address = 16'h1236;
    bus.memory_data_valid = 1'b1; bus.memory_data = 16'h5555;
    @(posedge clk); @(posedge clk); #2;
    n_chk++; if (bus.fsm_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.fsm_busy); end
    n_chk++; if (bus.memory_request !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.memory_request); end
    n_chk++; if (bus.write_data_array !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", bus.write_data_array); end
    n_chk++; if (bus.write_tag_array !== 1'b0) begin n_fail++; $display("FAIL reset_tag got %b want 0", bus.write_tag_array); end
    n_chk++; if (bus.critical_word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cwv got %b want 0", bus.critical_word_valid); end
    bus.memory_data_valid = 1'b0;
  endtask

  task automatic test_basic_fill();
    logic [2:0] w;
    reset_dut();
    cyc = 0; bus.miss_detected = 1'b1; bus.miss_address = 16'h1236;
    step();
    bus.miss_detected = 1'b0;
    repeat (15) step();
    for (int c = 0; c < 16; c++) begin
      n_chk++; if (busy_h[c] !== (c <= 12)) begin n_fail++; $display("FAIL basic_busy c=%0d got %b want %b", c, busy_h[c], c <= 12); end
      n_chk++; if (req_h[c] !== (c >= 1 && c <= 8)) begin n_fail++; $display("FAIL basic_req c=%0d got %b", c, req_h[c]); end
      n_chk++; if (wr_h[c] !== (c >= 5 && c <= 12)) begin n_fail++; $display("FAIL basic_wr c=%0d got %b", c, wr_h[c]); end
      n_chk++; if (tag_h[c] !== (c == 12)) begin n_fail++; $display("FAIL basic_tag c=%0d got %b", c, tag_h[c]); end
      n_chk++; if (cwv_h[c] !== (CWF && c == 5)) begin n_fail++; $display("FAIL basic_cwv c=%0d got %b", c, cwv_h[c]); end
      if (c >= 1 && c <= 8) begin
        w = exp_word(3'd3, c - 1);
        n_chk++; if (addr_h[c] !== {12'h123, w, 1'b0}) begin n_fail++; $display("FAIL basic_addr c=%0d got %h want %h", c, addr_h[c], {12'h123, w, 1'b0}); end
      end
      if (c >= 5 && c <= 12) begin
        w = exp_word(3'd3, c - 5);
        n_chk++; if (word_h[c] !== w) begin n_fail++; $display("FAIL basic_word c=%0d got %0d want %0d", c, word_h[c], w); end
        n_chk++; if (data_h[c] !== 16'hA000 + {12'h0, w, 1'b0}) begin n_fail++; $display("FAIL basic_data c=%0d got %h", c, data_h[c]); end
      end
    end
  endtask

  task automatic test_irregular();
    int nwr;
    logic [2:0] w;
    reset_dut();
    gap = 2;
    cyc = 0; bus.miss_detected = 1'b1; bus.miss_address = 16'h5678;
    step();
    bus.miss_detected = 1'b0;
    repeat (59) step();
    nwr = 0;
    for (int c = 0; c < 60; c++) begin
      if (wr_h[c] === 1'b1) begin
        w = exp_word(3'd4, nwr);
        n_chk++; if (word_h[c] !== w) begin n_fail++; $display("FAIL irr_word c=%0d got %0d want %0d", c, word_h[c], w); end
        n_chk++; if (data_h[c] !== 16'hA000 + {12'h0, w, 1'b0}) begin n_fail++; $display("FAIL irr_data c=%0d got %h", c, data_h[c]); end
        n_chk++; if (tag_h[c] !== (nwr == 7)) begin n_fail++; $display("FAIL irr_tag c=%0d write#%0d got %b", c, nwr, tag_h[c]); end
        nwr++;
      end else begin
        n_chk++; if (tag_h[c] !== 1'b0) begin n_fail++; $display("FAIL irr_tag_nowr c=%0d got %b want 0", c, tag_h[c]); end
      end
    end
    n_chk++; if (nwr !== 8) begin n_fail++; $display("FAIL irr_count got %0d want 8", nwr); end
    n_chk++; if (busy_h[59] !== 1'b0) begin n_fail++; $display("FAIL irr_busy_end got %b want 0", busy_h[59]); end
    gap = 0;
  endtask

  task automatic test_ignored();
    logic [2:0] w;
    reset_dut();
    cyc = 0; bus.miss_detected = 1'b1; bus.miss_address = 16'h1236;
    step();
    for (int c = 1; c < 16; c++) begin
      bus.miss_detected = (c == 3);
      bus.miss_address  = (c == 3) ? 16'h4000 : 16'h1236;
      step();
    end
    bus.miss_detected = 1'b0;
    for (int c = 1; c < 16; c++) begin
      n_chk++; if (busy_h[c] !== (c <= 12)) begin n_fail++; $display("FAIL ign_busy c=%0d got %b", c, busy_h[c]); end
      n_chk++; if (tag_h[c] !== (c == 12)) begin n_fail++; $display("FAIL ign_tag c=%0d got %b", c, tag_h[c]); end
      if (c <= 8) begin
        w = exp_word(3'd3, c - 1);
        n_chk++; if (addr_h[c] !== {12'h123, w, 1'b0}) begin n_fail++; $display("FAIL ign_addr c=%0d got %h", c, addr_h[c]); end
      end
    end
    // Memory valid while idle must not write the arrays.
    for (int k = 0; k < 2; k++) begin
      bus.memory_data_valid = 1'b1; bus.memory_data = 16'hBEEF;
      step();
    end
    for (int c = 16; c < 18; c++) begin
      n_chk++; if (wr_h[c] !== 1'b0) begin n_fail++; $display("FAIL idle_wr c=%0d got %b want 0", c, wr_h[c]); end
      n_chk++; if (tag_h[c] !== 1'b0) begin n_fail++; $display("FAIL idle_tag c=%0d got %b want 0", c, tag_h[c]); end
      n_chk++; if (busy_h[c] !== 1'b0) begin n_fail++; $display("FAIL idle_busy c=%0d got %b want 0", c, busy_h[c]); end
    end
  endtask

  task automatic test_reset_mid_fill();
    reset_dut();
    cyc = 0; bus.miss_detected = 1'b1; bus.miss_address = 16'h1236;
    step();
    bus.miss_detected = 1'b0;
    for (int c = 1; c < 25; c++) begin
      rst = (c == 7);
      step();
    end
    rst = 1'b0;
    n_chk++; if (busy_h[6] !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre got %b want 1", busy_h[6]); end
    for (int c = 8; c < 25; c++) begin
      n_chk++; if (busy_h[c] !== 1'b0) begin n_fail++; $display("FAIL rmid_busy c=%0d got %b want 0", c, busy_h[c]); end
      n_chk++; if (req_h[c] !== 1'b0) begin n_fail++; $display("FAIL rmid_req c=%0d got %b want 0", c, req_h[c]); end
      n_chk++; if (wr_h[c] !== 1'b0) begin n_fail++; $display("FAIL rmid_wr c=%0d got %b want 0", c, wr_h[c]); end
    end
    for (int c = 0; c < 25; c++) begin
      n_chk++; if (tag_h[c] !== 1'b0) begin n_fail++; $display("FAIL rmid_tag c=%0d got %b want 0", c, tag_h[c]); end
    end
  endtask

  task automatic test_back_to_back();
    int ntag;
    reset_dut();
    cyc = 0; bus.miss_detected = 1'b1; bus.miss_address = 16'h0010;
    step();
    for (int c = 1; c < 32; c++) begin
      bus.miss_detected = (c == 13);
      if (c == 13) bus.miss_address = 16'h0020;
      step();
    end
    bus.miss_detected = 1'b0;
    ntag = 0;
    for (int c = 0; c < 32; c++) begin
      n_chk++; if (busy_h[c] !== (c <= 25)) begin n_fail++; $display("FAIL b2b_busy c=%0d got %b want %b", c, busy_h[c], c <= 25); end
      n_chk++; if (tag_h[c] !== (c == 12 || c == 25)) begin n_fail++; $display("FAIL b2b_tag c=%0d got %b", c, tag_h[c]); end
      if (tag_h[c] === 1'b1) ntag++;
      if (c >= 14 && c <= 21) begin
        n_chk++; if (addr_h[c] !== 16'h0020 + 16'(2 * (c - 14))) begin n_fail++; $display("FAIL b2b_addr c=%0d got %h", c, addr_h[c]); end
      end
    end
    n_chk++; if (req_h[13] !== 1'b0) begin n_fail++; $display("FAIL b2b_req13 got %b want 0", req_h[13]); end
    n_chk++; if (req_h[14] !== 1'b1) begin n_fail++; $display("FAIL b2b_req14 got %b want 1", req_h[14]); end
    n_chk++; if (ntag !== 2) begin n_fail++; $display("FAIL b2b_ntag got %0d want 2", ntag); end
  endtask

  task automatic test_critical_word();
    logic [2:0] w;
    reset_dut();
    cyc = 0; bus.miss_detected = 1'b1; bus.miss_address = 16'h123A;
    step();
    bus.miss_detected = 1'b0;
    repeat (15) step();
    for (int c = 0; c < 16; c++) begin
      n_chk++; if (cwv_h[c] !== (CWF && c == 5)) begin n_fail++; $display("FAIL cwf_cwv c=%0d got %b", c, cwv_h[c]); end
      if (c >= 1 && c <= 8) begin
        w = exp_word(3'd5, c - 1);
        n_chk++; if (addr_h[c] !== {12'h123, w, 1'b0}) begin n_fail++; $display("FAIL cwf_addr c=%0d got %h want %h", c, addr_h[c], {12'h123, w, 1'b0}); end
      end
    end
    w = CWF ? 3'd5 : 3'd0;
    n_chk++; if (word_h[5] !== w) begin n_fail++; $display("FAIL cwf_first_word got %0d want %0d", word_h[5], w); end
    n_chk++; if (tag_h[12] !== 1'b1) begin n_fail++; $display("FAIL cwf_tag got %b want 1", tag_h[12]); end
  endtask

  initial begin
    bus.miss_detected = 1'b0; bus.miss_address = '0;
    bus.memory_data_valid = 1'b0; bus.memory_data = '0;
    test_reset();
    test_basic_fill();
    test_irregular();
    test_ignored();
    test_reset_mid_fill();
    test_back_to_back();
    test_critical_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the pipelined CPU's I-/D-cache arrays and the multi-cycle main memory (4-cycle-latency, pipelined word memory).
- On a cache miss it stalls the pipeline and streams the 16-byte block (8 words) from memory into the cache data array, then writes the tag.
- One instance per cache. The arbiter sharing memory between the two instances is outside this block.

Parameters:
- ADDR_W, 16, byte-address width.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two.
- OFFSET_W, 3, log2(WORDS_PER_BLOCK); word-offset width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache lookup missed this cycle.
- miss_address  in  ADDR_W  byte address of the missing access; held stable by the CPU while fsm_busy=1.
- memory_data  in  16  read data from main memory.
- memory_data_valid  in  1  memory_data is valid this cycle.
- fsm_busy  out  1  stall request to the pipeline.
- memory_request  out  1  read request to memory this cycle.
- memory_address  out  ADDR_W  word-aligned read address.
- write_data_array  out  1  write memory_data into the data array this cycle.
- data_array_word  out  OFFSET_W  word offset within the block for that write.
- write_tag_array  out  1  write the tag and valid bit for miss_address.
- critical_word_valid  out  1  missed word is on memory_data (see Optional Feature).

Behaviour:
- States: IDLE, FILL. Reset: state=IDLE, issue_cnt=0, recv_cnt=0. Every registered output is 0.
- fsm_busy = (state==FILL) | (state==IDLE & miss_detected). It is combinational so the pipeline stalls in the miss cycle itself.
- IDLE -> FILL on the clock edge where miss_detected=1. Both counters clear to 0 and block_base = miss_address[ADDR_W-1:OFFSET_W+1] is captured.
- FILL, issue side:
  - memory_request=1 while issue_cnt<WORDS_PER_BLOCK.
  - memory_address = {block_base, word(issue_cnt), 1'b0}.
  - issue_cnt increments every request cycle, so there are 8 back-to-back requests.
- FILL, receive side:
  - write_data_array = memory_data_valid. data_array_word = word(recv_cnt).
  - recv_cnt increments on each valid.
  - The block counts responses and does not depend on the memory latency value.
- Completion: on the valid with recv_cnt==WORDS_PER_BLOCK-1, write_tag_array=1 in that same cycle, alongside the final data write. Next state is IDLE; fsm_busy drops the following cycle unless miss_detected is high again.
- Default word order: word(n)=n, so addresses run base+0, +2, ... +14.
- Timing with 4-cycle memory, miss in cycle 0:
  - requests in cycles 1-8;
  - data writes in cycles 5-12;
  - tag write in cycle 12;
  - fsm_busy low in cycle 13.
- Boundaries:
  - miss_detected during FILL is ignored.
  - memory_data_valid in IDLE is ignored: no array writes.
  - rst mid-FILL returns to IDLE next edge; late memory responses are then ignored and no tag is written.
  - Counters saturate at WORDS_PER_BLOCK and never wrap within one fill.
  - miss_address bits [OFFSET_W:0] do not affect the default addresses.

Optional Feature:
- Macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - word(n) = (miss_address[OFFSET_W:1] + n) mod WORDS_PER_BLOCK. The fill starts at the missed word and wraps within the block.
  - critical_word_valid=1 on the first valid response of a fill (recv_cnt==0), so the CPU may forward early.
- Undefined:
  - word(n)=n.
  - critical_word_valid is tied to 0.
- All other timing is identical in both builds.

Decomposition:
- Package cache_pkg holds:
  - WORDS_PER_BLOCK, OFFSET_W, BLOCK_BYTES=16;
  - the fill_state_t enum {IDLE, FILL}.
- Sub-module fill_word_counter: OFFSET_W+1-bit counter with synchronous clear, increment enable and saturation at WORDS_PER_BLOCK. It is instantiated twice, as issue_cnt and recv_cnt.

Test Plan:
- Basic fill:
  - Stimulus: reset, then miss_address=16'h1236 in cycle 0; memory model returns data 16'hA000+offset 4 cycles after each request.
  - Response: requests at 1230,1232,...,123E in cycles 1-8; data writes offsets 0-7 with A000-A00E in cycles 5-12; write_tag_array only in cycle 12; fsm_busy high cycles 0-12, low in cycle 13.
- Irregular response timing: insert 2-cycle gaps in memory_data_valid.
  - Response: exactly 8 data writes in order, and the tag write coincides with the 8th.
- Ignored inputs: pulse miss_detected=1 with address 16'h4000 during FILL, and memory_data_valid in IDLE.
  - Response: no new fill, addresses unchanged, no array writes while IDLE.
- Reset mid-fill: assert rst in cycle 7.
  - Response: from the next cycle fsm_busy=0 and memory_request=0; later valids produce no writes; write_tag_array is never asserted.
- Back-to-back misses: miss at 16'h0010, then miss_detected held high for 16'h0020 in the cycle fsm_busy would drop.
  - Response: the second fill starts immediately; fsm_busy stays high continuously; two tag writes.
- Critical word first (with CACHE_FILL_CRITICAL_WORD_FIRST_EN): miss_address=16'h123A.
  - Response: request order 123A,123C,123E,1230,...,1238; critical_word_valid=1 only with the first data write (offset 5).
